wir_controller: RTL and testbench

Parametrised IEEE 1500 Wrapper Instruction Register (WIR) with integrated wrapper bypass (WBY), instruction decode and wrapper control generation. Holds the WIR shift and update stages, decodes the active instruction into mode bits, gates the WSC strobes, and steers WSO. Sits between the WSC/WSI/WSO pins and the WBR, core scan chains and MBIST controller.

---
 rtl/wir_pkg.sv | 29 ++
 rtl/wir_decode.sv | 49 ++++
 rtl/wir_controller.sv | 101 ++++++++++
 tb/tb_wir_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/wir_pkg.sv
// Shared definitions for the IEEE 1500 wrapper instruction register:
// opcodes, capture pattern and the decoded mode-bit bundle.
package wir_pkg;

    localparam logic [2:0] OP_WS_BYPASS = 3'd0;
    localparam logic [2:0] OP_WS_EXTEST = 3'd1;
    localparam logic [2:0] OP_WS_INTEST = 3'd2;
    localparam logic [2:0] OP_WP_EXTEST = 3'd3;
    localparam logic [2:0] OP_WS_SCAN   = 3'd4;
    localparam logic [2:0] OP_WP_SCAN   = 3'd5;
    localparam logic [2:0] OP_WS_MBIST  = 3'd6;
    localparam logic [2:0] OP_WS_CLAMP  = 3'd7;

    // Low bits loaded into the shift stage on capture; upper bits are zero.
    localparam logic [1:0] WIR_CAPTURE_LSBS = 2'b01;

    typedef struct packed {
        logic extest;
        logic intest;
        logic wpc;
        logic scanmode;
        logic mbistmode;
        logic bus_disable;
        logic wbr_concat;
        logic wpp_bypass;
        logic clamp;
    } wir_mode_t;

endpackage

// File: rtl/wir_decode.sv
// Combinational opcode decode; undefined opcodes fall back to WS_BYPASS
// with the illegal flag raised.
module wir_decode
    import wir_pkg::*;
#(
    parameter int IR_WIDTH = 4
) (
    input  logic [IR_WIDTH-1:0] i_op,
    output wir_mode_t           o_mode,
    output logic                o_illegal
);

    logic [2:0] w_sel;

    always_comb begin
        o_illegal = |i_op[IR_WIDTH-1:3];
        w_sel     = o_illegal ? OP_WS_BYPASS : i_op[2:0];
        o_mode    = '0;
        case (w_sel)
            OP_WS_BYPASS: o_mode.wpp_bypass = 1'b1;
            OP_WS_EXTEST: o_mode.extest = 1'b1;
            OP_WS_INTEST: o_mode.intest = 1'b1;
            OP_WP_EXTEST: begin
                o_mode.extest = 1'b1;
                o_mode.wpc    = 1'b1;
            end
            OP_WS_SCAN: begin
                o_mode.scanmode   = 1'b1;
                o_mode.wbr_concat = 1'b1;
            end
            OP_WP_SCAN: begin
                o_mode.scanmode   = 1'b1;
                o_mode.wbr_concat = 1'b1;
                o_mode.wpc        = 1'b1;
            end
            OP_WS_MBIST: begin
                o_mode.mbistmode   = 1'b1;
                o_mode.bus_disable = 1'b1;
            end
            OP_WS_CLAMP: begin
                o_mode.extest      = 1'b1;
                o_mode.bus_disable = 1'b1;
                o_mode.wpp_bypass  = 1'b1;
                o_mode.clamp       = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wir_controller.sv
// IEEE 1500 WIR with shift/update stages, WBY bypass bit, strobe gating,
// wrapper cell / scan control generation and WSO steering.
module wir_controller
    import wir_pkg::*;
#(
    parameter int                   IR_WIDTH = 4,
    parameter logic [IR_WIDTH-1:0]  RESET_OP = '0
) (
    input  logic                WRCK,
    input  logic                WRST,
    input  logic                SelectWIR,
    input  logic                ShiftWR,
    input  logic                CaptureWR,
    input  logic                UpdateWR,
    input  logic                WSI,
    input  logic                WPSE,
    input  logic                wbr_so,
    output logic                WSO,
    output logic [IR_WIDTH-1:0] wir_op,
    output logic                wir_capture,
    output logic                wir_shift,
    output logic                wir_update,
    output logic                wby_shift,
    output logic                extest,
    output logic                scanmode,
    output logic                mbistmode,
    output logic                bus_disable,
    output logic                wbr_concat,
    output logic                wpp_bypass,
    output logic                wpc,
    output logic                hold_inputs,
    output logic                hold_outputs,
    output logic                se,
    output logic                wse_inputs,
    output logic                wse_outputs,
    output logic                illegal_op
);

    localparam logic [IR_WIDTH-1:0] CAP_PAT = {{(IR_WIDTH-2){1'b0}}, WIR_CAPTURE_LSBS};

    logic [IR_WIDTH-1:0] r_shift;
    logic [IR_WIDTH-1:0] r_update;
    logic                r_wby;
    wir_mode_t           w_mode;
    logic                w_wby_capture;
    logic                w_m1;
    logic                w_m4;

    assign wir_capture   = SelectWIR & CaptureWR;
    assign wir_shift     = SelectWIR & ShiftWR;
    assign wir_update    = SelectWIR & UpdateWR;
    assign wby_shift     = ~SelectWIR & ShiftWR;
    assign w_wby_capture = ~SelectWIR & CaptureWR;

    always_ff @(posedge WRCK) begin
        if (WRST) begin
            r_shift  <= CAP_PAT;
            r_update <= RESET_OP;
            r_wby    <= 1'b0;
        end else begin
            if (wir_capture)
                r_shift <= CAP_PAT;
            else if (wir_shift)
                r_shift <= {WSI, r_shift[IR_WIDTH-1:1]};
            if (wir_update)
                r_update <= r_shift;
            if (w_wby_capture)
                r_wby <= 1'b0;
            else if (wby_shift)
                r_wby <= WSI;
        end
    end

    wir_decode #(.IR_WIDTH(IR_WIDTH)) u_decode (
        .i_op      (r_update),
        .o_mode    (w_mode),
        .o_illegal (illegal_op)
    );

    assign wir_op      = r_update;
    assign extest      = w_mode.extest;
    assign scanmode    = w_mode.scanmode;
    assign mbistmode   = w_mode.mbistmode;
    assign bus_disable = w_mode.bus_disable;
    assign wbr_concat  = w_mode.wbr_concat;
    assign wpp_bypass  = w_mode.wpp_bypass;
    assign wpc         = w_mode.wpc;

    assign WSO = SelectWIR ? r_shift[0] : (w_mode.wpp_bypass ? r_wby : wbr_so);

    // Parallel-port instructions hand cell control to WPSE instead of WSC strobes.
    assign w_m1 = w_mode.wpc ? WPSE : ~CaptureWR;
    assign w_m4 = w_mode.wpc ? WPSE : wby_shift;

    assign hold_outputs = w_mode.clamp | (w_mode.intest & w_m1);
    assign hold_inputs  = w_mode.clamp | (w_mode.extest & w_m1);
    assign se           = w_m4 & ~w_mode.extest & (w_mode.scanmode | w_mode.intest);
    assign wse_outputs  = (w_m4 | ~w_mode.extest) & (w_mode.scanmode | w_mode.extest);
    assign wse_inputs   = wse_outputs;

endmodule

// File: tb/tb_wir_controller.sv
// Randomised and directed bench for wir_controller against a behavioural
// model of the WIR/WBY state and the instruction table.
module tb_wir_controller;

    localparam int W = 4;

    logic WRCK = 1'b0;
    logic WRST = 1'b0, SelectWIR = 1'b0, ShiftWR = 1'b0, CaptureWR = 1'b0, UpdateWR = 1'b0;
    logic WSI = 1'b0, WPSE = 1'b0, wbr_so = 1'b0;
    logic WSO;
    logic [W-1:0] wir_op;
    logic wir_capture, wir_shift, wir_update, wby_shift;
    logic extest, scanmode, mbistmode, bus_disable, wbr_concat, wpp_bypass, wpc;
    logic hold_inputs, hold_outputs, se, wse_inputs, wse_outputs, illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    wir_controller #(.IR_WIDTH(W), .RESET_OP(4'd0)) dut (
        .WRCK(WRCK), .WRST(WRST), .SelectWIR(SelectWIR), .ShiftWR(ShiftWR),
        .CaptureWR(CaptureWR), .UpdateWR(UpdateWR), .WSI(WSI), .WPSE(WPSE),
        .wbr_so(wbr_so), .WSO(WSO), .wir_op(wir_op), .wir_capture(wir_capture),
        .wir_shift(wir_shift), .wir_update(wir_update), .wby_shift(wby_shift),
        .extest(extest), .scanmode(scanmode), .mbistmode(mbistmode),
        .bus_disable(bus_disable), .wbr_concat(wbr_concat), .wpp_bypass(wpp_bypass),
        .wpc(wpc), .hold_inputs(hold_inputs), .hold_outputs(hold_outputs), .se(se),
        .wse_inputs(wse_inputs), .wse_outputs(wse_outputs), .illegal_op(illegal_op)
    );

    always #5 WRCK = ~WRCK;

    // Behavioural model: instruction register contents as integers.
    int m_ir = 0, m_op = 0, m_wby = 0;
    bit m_valid = 1'b0;

    always @(posedge WRCK) begin
        int old_ir;
        old_ir = m_ir;
        if (WRST) begin
            m_ir = 1; m_op = 0; m_wby = 0; m_valid = 1'b1;
        end else begin
            if (SelectWIR && CaptureWR)      m_ir = 1;
            else if (SelectWIR && ShiftWR)   m_ir = (m_ir >> 1) + (int'(WSI) << (W-1));
            if (SelectWIR && UpdateWR)       m_op = old_ir;
            if (!SelectWIR && CaptureWR)     m_wby = 0;
            else if (!SelectWIR && ShiftWR)  m_wby = int'(WSI);
        end
    end

    function automatic logic [21:0] expected();
        int  e;
        bit  ill, x, it, pc, sc, mb, bd, wb, cl, m1, m4, ho, hi, s, ws, so;
        ill = (m_op > 7);
        e   = ill ? 0 : m_op;
        x   = (e == 1 || e == 3 || e == 7);
        it  = (e == 2);
        pc  = (e == 3 || e == 5);
        sc  = (e == 4 || e == 5);
        mb  = (e == 6);
        bd  = (e == 6 || e == 7);
        wb  = (e == 0 || e == 7);
        cl  = (e == 7);
        m1  = pc ? WPSE : !CaptureWR;
        m4  = pc ? WPSE : (!SelectWIR && ShiftWR);
        ho  = cl || (it && m1);
        hi  = cl || (x && m1);
        s   = m4 && !x && (sc || it);
        ws  = (m4 || !x) && (sc || x);
        so  = SelectWIR ? m_ir[0] : (wb ? m_wby[0] : wbr_so);
        return {so, 4'(m_op),
                SelectWIR & CaptureWR, SelectWIR & ShiftWR, SelectWIR & UpdateWR, !SelectWIR & ShiftWR,
                x, sc, mb, bd, sc, wb, pc, hi, ho, s, ws, ws, ill};
    endfunction

    always @(negedge WRCK) begin
        logic [21:0] act, exp;
        if (m_valid) begin
            act = {WSO, wir_op, wir_capture, wir_shift, wir_update, wby_shift,
                   extest, scanmode, mbistmode, bus_disable, wbr_concat, wpp_bypass, wpc,
                   hold_inputs, hold_outputs, se, wse_inputs, wse_outputs, illegal_op};
            exp = expected();
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got=%h want=%h", $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are then settled by #1 after the falling edge.
    task automatic tick(input logic rst, sel, cap, sh, upd, wsi, wpse);
        @(posedge WRCK);
        #1;
        WRST = rst; SelectWIR = sel; CaptureWR = cap; ShiftWR = sh;
        UpdateWR = upd; WSI = wsi; WPSE = wpse; wbr_so = 1'($urandom);
        @(negedge WRCK);
        #1;
    endtask

    task automatic load_op(input logic [W-1:0] op, output logic [W-1:0] so);
        tick(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) begin
            tick(0, 1, 0, 1, 0, op[i], 0);
            so[i] = WSO;
        end
        tick(0, 1, 0, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] so;
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0);
        chk("rst_wir_op", int'(wir_op), 0);
        chk("rst_wpp_bypass", int'(wpp_bypass), 1);
        chk("rst_wso", int'(WSO), 1);
        chk("rst_quiet", int'({extest, scanmode, mbistmode, bus_disable, wbr_concat, wpc,
                               hold_inputs, hold_outputs, se, wse_inputs, illegal_op}), 0);

        load_op(4'd2, so);
        chk("intest_shout", int'(so), 4'b0001);
        chk("intest_op", int'(wir_op), 2);
        tick(0, 0, 1, 0, 0, 0, 0);
        chk("intest_hold_cap", int'(hold_outputs), 0);
        chk("intest_se_cap", int'(se), 0);
        tick(0, 0, 0, 1, 0, 0, 0);
        chk("intest_hold_sh", int'(hold_outputs), 1);
        chk("intest_se_sh", int'(se), 1);

        load_op(4'd3, so);
        tick(0, 0, 0, 0, 0, 0, 1);
        chk("wpext_hold_in1", int'(hold_inputs), 1);
        chk("wpext_wse1", int'({wse_inputs, wse_outputs, se}), 3'b110);
        tick(0, 0, 1, 0, 0, 0, 0);
        chk("wpext_hold_in0", int'(hold_inputs), 0);
        chk("wpext_wse0", int'({wse_inputs, wse_outputs, se}), 3'b000);

        load_op(4'd0, so);
        tick(0, 0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 1, 0);
        chk("byp_wso0", int'(WSO), 0);
        tick(0, 0, 0, 1, 0, 0, 0);
        chk("byp_wso1", int'(WSO), 1);
        tick(0, 0, 0, 1, 0, 1, 0);
        chk("byp_wso2", int'(WSO), 0);

        load_op(4'b1001, so);
        chk("ill_flag", int'(illegal_op), 1);
        chk("ill_modes", int'({wpp_bypass, extest, scanmode, mbistmode, bus_disable, wpc}), 6'b100000);

        load_op(4'd7, so);
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 1'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom));
            chk("clamp_hold", int'({hold_inputs, hold_outputs}), 3);
        end

        load_op(4'd5, so);
        tick(0, 1, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 1, 0, 1, 0);
        tick(0, 1, 0, 1, 0, 1, 0);
        tick(1, 1, 0, 1, 1, 1, 0);
        chk("midrst_op", int'(wir_op), 5);
        for (int i = 0; i < W; i++) begin
            tick(0, 1, 0, 1, 0, (i == 1 || i == 2) ? 1'b1 : 1'b0, 0);
            so[i] = WSO;
            if (i == 0) chk("midrst_op_after", int'(wir_op), 0);
        end
        chk("midrst_shout", int'(so), 4'b0001);
        tick(0, 1, 0, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0);
        chk("midrst_reload", int'(wir_op), 6);
        chk("midrst_mbist", int'(mbistmode), 1);

        for (int i = 0; i < 400; i++)
            tick(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
